// File: rtl/fir_accel_host_if.sv
// Stream, coefficient-config and accelerator-side signals of the FIR accelerator host.
//  slave  : view taken by fir_accel_host (consumes samples/cfg, drives the accelerator)
//  master : view taken by the surrounding fabric / accelerator model
//  in_*   : sample stream, valid/ready
//  out_*  : result stream, valid/ready, show-ahead data
//  cfg_*  : coefficient write port, accepted on cfg_wr_en & cfg_ready
//  acc_*  : start/done transaction and coefficient write strobe to the accelerator
interface fir_accel_host_if #(
  parameter int TAPS  = 8,
  parameter int WIDTH = 32
);
  localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1;

  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_data;
  logic                    cfg_wr_en;
  logic [AW-1:0]           cfg_wr_addr;
  logic signed [WIDTH-1:0] cfg_wr_data;
  logic                    cfg_ready;
  logic                    acc_start;
  logic signed [WIDTH-1:0] acc_sample;
  logic                    acc_done;
  logic signed [WIDTH-1:0] acc_result;
  logic                    acc_coeff_wr_en;
  logic [AW-1:0]           acc_coeff_wr_addr;
  logic signed [WIDTH-1:0] acc_coeff_wr_data;

  modport slave (
    input  in_valid, in_data, out_ready, cfg_wr_en, cfg_wr_addr, cfg_wr_data,
           acc_done, acc_result,
    output in_ready, out_valid, out_data, cfg_ready, acc_start, acc_sample,
           acc_coeff_wr_en, acc_coeff_wr_addr, acc_coeff_wr_data
  );

  modport master (
    output in_valid, in_data, out_ready, cfg_wr_en, cfg_wr_addr, cfg_wr_data,
           acc_done, acc_result,
    input  in_ready, out_valid, out_data, cfg_ready, acc_start, acc_sample,
           acc_coeff_wr_en, acc_coeff_wr_addr, acc_coeff_wr_data
  );
endinterface

// File: rtl/fir_accel_host.sv
// FIR accelerator host: runs one start/done transaction per accepted sample,
// forwards coefficient writes, buffers results in a show-ahead FIFO and aborts
// a transaction whose done does not arrive within TIMEOUT cycles.
//  clk, rst_n      : clock, asynchronous active-low reset
//  bus (slave)     : sample/result streams, cfg port, accelerator signals
//  busy            : high while waiting for acc_done
//  timeout_err     : sticky watchdog flag, cleared by clear_err
//  clear_err       : clears timeout_err (wins over a same-cycle set)
//  result_count    : results pushed since reset, wrapping
module fir_accel_host #(
  parameter int TAPS      = 8,
  parameter int WIDTH     = 32,
  parameter int OUT_DEPTH = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fir_accel_host_if.slave       bus,
  output logic                  busy,
  output logic                  timeout_err,
  input  logic                  clear_err,
  output logic [31:0]           result_count
);
  localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic {IDLE, WAIT_DONE} state_t;
  state_t state, state_nxt;

  logic [TW-1:0]           timer;
  logic                    start_q;
  logic signed [WIDTH-1:0] sample_q;
  logic                    cwr_en_q;
  logic [AW-1:0]           cwr_addr_q;
  logic signed [WIDTH-1:0] cwr_data_q;

  logic signed [WIDTH-1:0] mem [OUT_DEPTH];
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           count;

  logic cfg_acc, in_acc, done_ok, tmo, push, pop;

  // Config has priority over samples; a high acc_done (possibly a stale one
  // after an abort) also blocks new samples so it cannot be mistaken for the
  // next transaction's result.
  assign bus.cfg_ready = (state == IDLE);
  assign bus.in_ready  = (state == IDLE) && !bus.cfg_wr_en && !bus.acc_done &&
                         (count < CW'(OUT_DEPTH));
  assign cfg_acc = bus.cfg_wr_en && bus.cfg_ready;
  assign in_acc  = bus.in_valid && bus.in_ready;

  // acc_done is not trusted in the start cycle.
  assign done_ok = (state == WAIT_DONE) && !start_q && bus.acc_done;
  assign tmo     = (state == WAIT_DONE) && !bus.acc_done && (timer == TW'(TIMEOUT - 1));
  assign push    = done_ok;
  assign pop     = bus.out_valid && bus.out_ready;

  assign bus.out_valid         = (count != '0);
  assign bus.out_data          = mem[rd_ptr];
  assign bus.acc_start         = start_q;
  assign bus.acc_sample        = sample_q;
  assign bus.acc_coeff_wr_en   = cwr_en_q;
  assign bus.acc_coeff_wr_addr = cwr_addr_q;
  assign bus.acc_coeff_wr_data = cwr_data_q;
  assign busy                  = (state == WAIT_DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (in_acc) state_nxt = WAIT_DONE;
      WAIT_DONE: if (done_ok || tmo) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      timer        <= '0;
      start_q      <= 1'b0;
      sample_q     <= '0;
      cwr_en_q     <= 1'b0;
      cwr_addr_q   <= '0;
      cwr_data_q   <= '0;
      timeout_err  <= 1'b0;
      result_count <= '0;
    end else begin
      state    <= state_nxt;
      start_q  <= in_acc;
      cwr_en_q <= cfg_acc;
      if (cfg_acc) begin
        cwr_addr_q <= bus.cfg_wr_addr;
        cwr_data_q <= bus.cfg_wr_data;
      end
      if (in_acc) begin
        sample_q <= bus.in_data;
        timer    <= '0;
      end else if (state == WAIT_DONE) begin
        timer <= timer + 1'b1;
      end
      if (push) result_count <= result_count + 32'd1;
      if (clear_err)  timeout_err <= 1'b0;
      else if (tmo)   timeout_err <= 1'b1;
    end
  end

  // Result FIFO. A push never meets a full FIFO because a sample is only
  // accepted while a slot is free and only one transaction is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.acc_result;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_accel_host.sv
module tb_fir_accel_host;
  localparam int TAPS = 8, WIDTH = 32, OUT_DEPTH = 4, TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear_err = 1'b0;
  logic        busy, timeout_err;
  logic [31:0] result_count;

  fir_accel_host_if #(.TAPS(TAPS), .WIDTH(WIDTH)) bus();

  fir_accel_host #(.TAPS(TAPS), .WIDTH(WIDTH), .OUT_DEPTH(OUT_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy),
    .timeout_err(timeout_err), .clear_err(clear_err), .result_count(result_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Accelerator result function used by the responder and the reference model.
  function automatic logic signed [31:0] f(input logic signed [31:0] x);
    return x * 32'sd3 + 32'sd1;
  endfunction

  // Responder: done D cycles after the start cycle (D=0: never). Not reset by
  // rst_n, so a pending done can arrive late.
  int                 resp_d = 9;
  int                 resp_cnt = 0;
  logic signed [31:0] resp_x = '0;
  logic               resp_done = 1'b0;
  logic signed [31:0] resp_res = '0;
  assign bus.acc_done   = resp_done;
  assign bus.acc_result = resp_res;

  always @(posedge clk) begin
    resp_done <= 1'b0;
    if (bus.acc_start) begin
      resp_x   <= bus.acc_sample;
      resp_cnt <= resp_d - 1;
      if (resp_d == 1) begin
        resp_done <= 1'b1;
        resp_res  <= f(bus.acc_sample);
      end
    end else if (resp_cnt == 1) begin
      resp_done <= 1'b1;
      resp_res  <= f(resp_x);
      resp_cnt  <= 0;
    end else if (resp_cnt > 1) begin
      resp_cnt <= resp_cnt - 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: every accepted sample whose done lands inside the
  // TIMEOUT-cycle wait window yields f(sample), delivered in order.
  logic signed [31:0] exp_q[$];
  int                 mdl_cnt = 0;
  int                 start_cyc[$];

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      exp_q.delete();
      mdl_cnt = 0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("pop_unexpected", 64'd1, 64'd0);
        else chk("pop_data", bus.out_data, exp_q.pop_front());
      end
      if (bus.in_valid && bus.in_ready && resp_d != 0 && resp_d < TIMEOUT) begin
        exp_q.push_back(f(bus.in_data));
        mdl_cnt++;
      end
      if (bus.acc_start) start_cyc.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present a sample and hold it until accepted; returns 1 ns after the accept edge.
  task automatic send(input logic signed [31:0] x);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    @(negedge clk);
    while (!bus.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input int lim, output int n);
    n = 0;
    while (!bus.out_valid && n < lim) begin
      step();
      n++;
    end
    chk("out_valid_arrives", bus.out_valid, 1);
  endtask

  task automatic pop();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  typedef struct { logic [2:0] a; logic signed [31:0] d; } cfg_t;
  typedef struct { logic signed [31:0] x; int d; logic signed [31:0] res; int lat; } vec_t;
  cfg_t ct[8];
  vec_t vt[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, viol;
    logic rnd_done;
    for (int i = 0; i < 8; i++) ct[i] = '{3'(i), 32'(i + 1)};
    vt[0] = '{32'sd5,    9, 32'sd16,  10};
    vt[1] = '{-32'sd3,   9, -32'sd8,  10};
    vt[2] = '{32'sd100,  2, 32'sd301,  3};
    vt[3] = '{32'sd0,   20, 32'sd1,   21};
    vt[4] = '{-32'sd1,   5, -32'sd2,   6};

    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    bus.cfg_wr_en = 1'b0; bus.cfg_wr_addr = '0; bus.cfg_wr_data = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_cfg_ready", bus.cfg_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_acc_start", bus.acc_start, 0);
    chk("rst_coeff_en", bus.acc_coeff_wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_result_count", result_count, 0);
    rst_n = 1'b1;
    step();

    // Coefficient writes, with a competing sample that must lose.
    bus.in_valid = 1'b1; bus.in_data = 32'sd77;
    for (int i = 0; i < 8; i++) begin
      bus.cfg_wr_en = 1'b1; bus.cfg_wr_addr = ct[i].a; bus.cfg_wr_data = ct[i].d;
      #1;
      chk("cfg_in_ready_low", bus.in_ready, 0);
      chk("cfg_no_start", bus.acc_start, 0);
      if (i > 0) begin
        chk("cfg_strobe_en", bus.acc_coeff_wr_en, 1);
        chk("cfg_strobe_addr", bus.acc_coeff_wr_addr, ct[i-1].a);
        chk("cfg_strobe_data", bus.acc_coeff_wr_data, ct[i-1].d);
      end
      @(posedge clk); #1;
    end
    chk("cfg_strobe_en", bus.acc_coeff_wr_en, 1);
    chk("cfg_strobe_addr", bus.acc_coeff_wr_addr, ct[7].a);
    chk("cfg_strobe_data", bus.acc_coeff_wr_data, ct[7].d);
    bus.cfg_wr_en = 1'b0; bus.in_valid = 1'b0;
    step();
    chk("cfg_strobe_off", bus.acc_coeff_wr_en, 0);
    chk("cfg_sample_not_taken", busy, 0);

    // Single transactions: start pulse, latency and result per vector.
    for (int i = 0; i < 5; i++) begin
      resp_d = vt[i].d;
      send(vt[i].x);
      chk("vec_start", bus.acc_start, 1);
      chk("vec_sample", bus.acc_sample, vt[i].x);
      chk("vec_busy", busy, 1);
      wait_out(100, n);
      chk("vec_latency", n, vt[i].lat);
      chk("vec_result", bus.out_data, vt[i].res);
      chk("vec_start_single", bus.acc_start, 0);
      pop();
      chk("vec_fifo_empty", bus.out_valid, 0);
    end
    chk("vec_result_count", result_count, 5);

    // Back-to-back throughput.
    resp_d = 9; bus.out_ready = 1'b1; start_cyc.delete();
    send(32'sd5);
    send(-32'sd3);
    repeat (15) step();
    chk("tput_starts", start_cyc.size(), 2);
    if (start_cyc.size() == 2) chk("tput_spacing", start_cyc[1] - start_cyc[0], 11);
    chk("tput_count", result_count, 7);
    chk("tput_drained", exp_q.size(), 0);
    bus.out_ready = 1'b0;

    // Backpressure: FIFO fills at OUT_DEPTH results.
    resp_d = 9;
    fork
      begin
        for (int k = 0; k < 6; k++) send($urandom);
      end
      begin
        repeat (80) step();
        chk("bp_out_valid", bus.out_valid, 1);
        chk("bp_in_ready_low", bus.in_ready, 0);
        chk("bp_count4", result_count, 11);
        chk("bp_idle", busy, 0);
        bus.out_ready = 1'b1;
      end
    join
    repeat (20) step();
    chk("bp_drained", exp_q.size(), 0);
    chk("bp_count6", result_count, 13);
    chk("bp_empty", bus.out_valid, 0);
    bus.out_ready = 1'b0;

    // Watchdog: done never arrives.
    resp_d = 0;
    send(32'sd7);
    n = 0;
    while (busy && n < 200) begin
      n++;
      step();
    end
    chk("tmo_wait_cycles", n, 64);
    chk("tmo_err", timeout_err, 1);
    chk("tmo_no_push", bus.out_valid, 0);
    chk("tmo_count", result_count, 13);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    chk("tmo_cleared", timeout_err, 0);

    // Late done after abort, with clear_err held across the abort cycle.
    resp_d = 70; clear_err = 1'b1;
    send(32'sd9);
    n = 0;
    while (busy && n < 200) begin
      n++;
      step();
    end
    chk("late_clear_wins", timeout_err, 0);
    n = 0;
    while (!resp_done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("late_done_seen", resp_done, 1);
    chk("late_in_ready_low", bus.in_ready, 0);
    clear_err = 1'b0;
    step(); step();
    chk("late_no_push", bus.out_valid, 0);
    chk("late_count", result_count, 13);

    resp_d = 9;
    send(32'sd11);
    wait_out(100, n);
    chk("tmo_recover_result", bus.out_data, 32'sd34);
    pop();
    chk("tmo_recover_count", result_count, 14);

    // Config held during WAIT_DONE is deferred to IDLE.
    resp_d = 9; bus.out_ready = 1'b1;
    send(32'sd2);
    bus.cfg_wr_en = 1'b1; bus.cfg_wr_addr = 3'd5; bus.cfg_wr_data = 32'h55;
    viol = 0; n = 0;
    while (busy && n < 100) begin
      if (bus.cfg_ready || bus.acc_coeff_wr_en || bus.in_ready) viol++;
      n++;
      step();
    end
    chk("cfgwait_blocked", viol, 0);
    chk("cfgwait_ready_idle", bus.cfg_ready, 1);
    chk("cfgwait_no_strobe_yet", bus.acc_coeff_wr_en, 0);
    step();
    chk("cfgwait_strobe", bus.acc_coeff_wr_en, 1);
    chk("cfgwait_addr", bus.acc_coeff_wr_addr, 5);
    chk("cfgwait_data", bus.acc_coeff_wr_data, 32'h55);
    bus.cfg_wr_en = 1'b0;
    step();
    chk("cfgwait_strobe_off", bus.acc_coeff_wr_en, 0);
    repeat (3) step();
    chk("cfgwait_count", result_count, 15);
    bus.out_ready = 1'b0;

    // Randomized traffic against the reference model.
    rnd_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          resp_d = $urandom_range(2, 20);
          send($urandom);
          repeat ($urandom_range(0, 3)) step();
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          step();
        end
      end
    join
    bus.out_ready = 1'b1;
    repeat (40) step();
    chk("rnd_drained", exp_q.size(), 0);
    chk("rnd_count", result_count, 32'(mdl_cnt));
    bus.out_ready = 1'b0;

    // Reset in the middle of a transaction with a buffered result.
    resp_d = 2;
    send(32'sd21);
    wait_out(100, n);
    resp_d = 9;
    send(32'sd22);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", bus.out_valid, 0);
    chk("mrst_out_data", bus.out_data, 0);
    chk("mrst_acc_start", bus.acc_start, 0);
    chk("mrst_acc_sample", bus.acc_sample, 0);
    chk("mrst_coeff_en", bus.acc_coeff_wr_en, 0);
    chk("mrst_coeff_addr", bus.acc_coeff_wr_addr, 0);
    chk("mrst_coeff_data", bus.acc_coeff_wr_data, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_timeout_err", timeout_err, 0);
    chk("mrst_count", result_count, 0);
    step();
    rst_n = 1'b1;
    n = 0;
    while (!resp_done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mrst_late_done_seen", resp_done, 1);
    chk("mrst_late_in_ready_low", bus.in_ready, 0);
    step(); step();
    chk("mrst_no_push", bus.out_valid, 0);
    chk("mrst_count_after", result_count, 0);

    resp_d = 4; bus.out_ready = 1'b0;
    send(-32'sd7);
    wait_out(100, n);
    chk("mrst_recover_result", bus.out_data, -32'sd20);
    pop();
    chk("mrst_recover_count", result_count, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
